mri_address_unit: RTL and testbench

//  Memory-reference-instruction (MRI) address unit: the stage upstream of memory_controller.

---
 rtl/mri_address_unit.sv | 178 +++++++++++++++++
 tb/tb_mri_address_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mri_address_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mri_address_unit
// Purpose  : Resolves the effective address of a 12-bit memory-reference
//            instruction (page-zero or current-page, direct or indirect).
//            Indirect pointers held in the auto-index window are
//            pre-incremented and written back. The operand can then be
//            fetched. Drives memory_controller and returns eff_addr/operand
//            to the execute stage.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            start, pc,
//            instruction,
//            need_operand      - request; sampled only while idle
//            mem_*             - memory_controller address/data/enables/type
//            eff_addr, operand - results, updated together with done
//            busy, done        - status, one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module mri_address_unit #(
  parameter logic [11:0] AUTOINC_BASE  = 12'o0010,
  parameter int unsigned AUTOINC_COUNT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] pc,
  input  logic [11:0] instruction,
  input  logic        need_operand,
  input  logic [11:0] mem_read_data,
  output logic [11:0] mem_address,
  output logic [11:0] mem_write_data,
  output logic        mem_read_enable,
  output logic        mem_read_type,
  output logic        mem_write_enable,
  output logic [11:0] eff_addr,
  output logic [11:0] operand,
  output logic        busy,
  output logic        done
);

  localparam logic        DATA_READ    = 1'b1;
  localparam logic [12:0] AUTOINC_LO   = {1'b0, AUTOINC_BASE};
  localparam logic [12:0] AUTOINC_HI   = AUTOINC_LO + 13'(AUTOINC_COUNT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IND_RD   = 3'd1,
    S_IND_WAIT = 3'd2,
    S_AUTO_WR  = 3'd3,
    S_OP_RD    = 3'd4,
    S_OP_WAIT  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t      state_q;
  logic [11:0] dea_q;       // direct EA of the latched instruction
  logic        need_q;
  logic [11:0] ea_q;        // resolved EA, published at completion
  logic [11:0] opnd_q;      // fetched operand, published at completion
  logic [11:0] addr_q;
  logic [11:0] wdata_q;
  logic        rd_en_q;
  logic        wr_en_q;
  logic [11:0] eff_addr_q;
  logic [11:0] operand_q;
  logic        done_q;

  logic [11:0] w_dea;
  logic        w_auto;
  logic [11:0] w_ptr_inc;
  logic        w_unused_bits;

  assign w_dea     = instruction[7] ? {pc[11:7], instruction[6:0]}
                                    : {5'b0, instruction[6:0]};
  // Window test uses the direct EA only; the pointer value never matters.
  assign w_auto    = ({1'b0, dea_q} >= AUTOINC_LO) && ({1'b0, dea_q} < AUTOINC_HI);
  assign w_ptr_inc = mem_read_data + 12'd1;   // wraps 7777 -> 0000
  // Opcode and in-page PC bits play no part in address resolution.
  assign w_unused_bits = ^{instruction[11:9], pc[6:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dea_q      <= '0;
      need_q     <= 1'b0;
      ea_q       <= '0;
      opnd_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      eff_addr_q <= '0;
      operand_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      // Enables and done are single-cycle pulses unless a state re-arms them.
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dea_q  <= w_dea;
            need_q <= need_operand;
            ea_q   <= w_dea;
            if (instruction[8]) begin
              addr_q  <= w_dea;
              rd_en_q <= 1'b1;
              state_q <= S_IND_RD;
            end else if (need_operand) begin
              addr_q  <= w_dea;
              rd_en_q <= 1'b1;
              state_q <= S_OP_RD;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_IND_RD: state_q <= S_IND_WAIT;
        S_IND_WAIT: begin
          if (w_auto) begin
            ea_q    <= w_ptr_inc;
            addr_q  <= dea_q;
            wdata_q <= w_ptr_inc;
            wr_en_q <= 1'b1;
            state_q <= S_AUTO_WR;
          end else begin
            ea_q <= mem_read_data;
            if (need_q) begin
              addr_q  <= mem_read_data;
              rd_en_q <= 1'b1;
              state_q <= S_OP_RD;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_AUTO_WR: begin
          if (need_q) begin
            addr_q  <= ea_q;
            rd_en_q <= 1'b1;
            state_q <= S_OP_RD;
          end else begin
            state_q <= S_DONE;
          end
        end
        S_OP_RD: state_q <= S_OP_WAIT;
        S_OP_WAIT: begin
          opnd_q  <= mem_read_data;
          state_q <= S_DONE;
        end
        S_DONE: begin
          // Results and done change on the same edge so they are coherent.
          done_q     <= 1'b1;
          eff_addr_q <= ea_q;
          if (need_q) begin
            operand_q <= opnd_q;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_address      = addr_q;
  assign mem_write_data   = wdata_q;
  assign mem_read_enable  = rd_en_q;
  assign mem_write_enable = wr_en_q;
  assign mem_read_type    = DATA_READ;
  assign eff_addr         = eff_addr_q;
  assign operand          = operand_q;
  assign done             = done_q;
  assign busy             = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mri_address_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mri_address_unit
// Purpose  : Self-checking bench for mri_address_unit with a behavioural
//            memory, directed scenarios and randomized transactions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mri_address_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] pc = '0;
  logic [11:0] instruction = '0;
  logic        need_operand = 1'b0;
  logic [11:0] mem_read_data = '0;
  logic [11:0] mem_address;
  logic [11:0] mem_write_data;
  logic        mem_read_enable;
  logic        mem_read_type;
  logic        mem_write_enable;
  logic [11:0] eff_addr;
  logic [11:0] operand;
  logic        busy;
  logic        done;

  mri_address_unit dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .pc              (pc),
    .instruction     (instruction),
    .need_operand    (need_operand),
    .mem_read_data   (mem_read_data),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_read_enable (mem_read_enable),
    .mem_read_type   (mem_read_type),
    .mem_write_enable(mem_write_enable),
    .eff_addr        (eff_addr),
    .operand         (operand),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT and the reference image kept by the model.
  logic [11:0] mem     [4096];
  logic [11:0] ref_mem [4096];

  always @(posedge clk) begin
    if (mem_read_enable)  mem_read_data <= mem[mem_address];
    if (mem_write_enable) mem[mem_address] <= mem_write_data;
  end

  // Bus monitor.
  int          rd_cnt, wr_cnt, ovl_cnt, done_cnt;
  logic [11:0] rd_addrs[$];
  logic [11:0] wr_addr_l, wr_data_l;

  always @(posedge clk) begin
    if (mem_read_enable) begin
      rd_cnt++;
      rd_addrs.push_back(mem_address);
    end
    if (mem_write_enable) begin
      wr_cnt++;
      wr_addr_l = mem_address;
      wr_data_l = mem_write_data;
    end
    if (mem_read_enable && mem_write_enable) ovl_cnt++;
    if (done) done_cnt++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    rd_addrs.delete();
  endtask

  task automatic preload(input logic [11:0] a, input logic [11:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // One transaction: model predicts, DUT runs, results compared.
  task automatic run_txn(input logic [11:0] p, input logic [11:0] inst,
                         input logic need, input bit poke);
    logic [11:0] dea, ptr, ea, opnd;
    logic [11:0] exp_rd[$];
    bit          ind, auto_i, seen;
    int          exp_n, n;
    dea    = inst[7] ? {p[11:7], inst[6:0]} : {5'b0, inst[6:0]};
    ind    = inst[8];
    auto_i = ind && (dea >= 12'o0010) && (dea <= 12'o0017);
    ea     = dea;
    ptr    = '0;
    if (ind) begin
      exp_rd.push_back(dea);
      ptr = ref_mem[dea];
      if (auto_i) begin
        ptr = ptr + 12'd1;
        ref_mem[dea] = ptr;
      end
      ea = ptr;
    end
    opnd = ref_mem[ea];
    if (need) exp_rd.push_back(ea);
    exp_n = 1 + (ind ? (auto_i ? 3 : 2) : 0) + (need ? 2 : 0);

    @(negedge clk);
    clear_mon();
    start = 1'b1; pc = p; instruction = inst; need_operand = need;
    @(posedge clk);
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
    start = 1'b0;
    if (poke) begin
      start = 1'b1;
      pc = 12'($urandom);
      instruction = 12'($urandom);
      need_operand = ~need;
    end
    seen = 0; n = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (done) begin
        seen = 1; n = k;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(n), 32'(exp_n));
    check("eff_addr", 32'(eff_addr), 32'(ea));
    if (need) check("operand", 32'(operand), 32'(opnd));
    repeat (3) @(negedge clk);
    check("done_count", 32'(done_cnt), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
    check("rd_overlap", 32'(ovl_cnt), 32'd0);
    check("rd_count", 32'(rd_cnt), 32'(exp_rd.size()));
    for (int j = 0; j < exp_rd.size() && j < rd_addrs.size(); j++)
      check("rd_addr", 32'(rd_addrs[j]), 32'(exp_rd[j]));
    check("wr_count", 32'(wr_cnt), auto_i ? 32'd1 : 32'd0);
    if (auto_i) begin
      check("wr_addr", 32'(wr_addr_l), 32'(dea));
      check("wr_data", 32'(wr_data_l), 32'(ptr));
      check("mem_image", 32'(mem[dea]), 32'(ref_mem[dea]));
    end
  endtask

  initial begin
    logic [11:0] rinst;
    for (int a = 0; a < 4096; a++) begin
      mem[a]     = 12'($urandom);
      ref_mem[a] = mem[a];
    end
    clear_mon();
    ovl_cnt = 0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_done",      32'(done), 32'd0);
    check("rst_rd_en",     32'(mem_read_enable), 32'd0);
    check("rst_wr_en",     32'(mem_write_enable), 32'd0);
    check("rst_rd_type",   32'(mem_read_type), 32'd1);
    check("rst_addr",      32'(mem_address), 32'd0);
    check("rst_wdata",     32'(mem_write_data), 32'd0);
    check("rst_eff_addr",  32'(eff_addr), 32'd0);
    check("rst_operand",   32'(operand), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed scenarios.
    run_txn(12'o0200, 12'o1205, 1'b0, 0);            // current-page direct
    preload(12'o0020, 12'o3456);
    run_txn(12'o0200, 12'o1420, 1'b0, 0);            // page-zero indirect
    preload(12'o0010, 12'o7777);
    run_txn(12'o0200, 12'o1410, 1'b0, 0);            // auto-index wrap
    preload(12'o0205, 12'o1234);
    run_txn(12'o0200, 12'o1205, 1'b1, 0);            // direct with operand
    run_txn(12'o0200, 12'o1012, 1'b1, 0);            // direct in window: no write
    run_txn(12'o0000, 12'o1610, 1'b1, 0);            // P=1 in page 0 reaches window
    preload(12'o0017, 12'o0477);
    run_txn(12'o4321, 12'o0417, 1'b1, 1);            // last window slot, start poked
    run_txn(12'o3333, 12'o1205, 1'b0, 1);            // direct, start poked

    // Reset during IND_WAIT of an auto-index access.
    preload(12'o0011, 12'o0100);
    @(negedge clk);
    clear_mon();
    start = 1'b1; pc = 12'o0200; instruction = 12'o1411; need_operand = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_busy",  32'(busy), 32'd0);
    check("rst_mid_wr_en", 32'(mem_write_enable), 32'd0);
    check("rst_mid_done",  32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_wr_cnt",   32'(wr_cnt), 32'd0);
    check("rst_mid_done_cnt", 32'(done_cnt), 32'd0);
    check("rst_mid_mem",      32'(mem[12'o0011]), 32'o0100);
    check("rst_mid_eff_addr", 32'(eff_addr), 32'd0);

    // Randomized transactions, biased toward the auto-index window.
    for (int t = 0; t < 40; t++) begin
      rinst = 12'($urandom);
      rinst[11:9] = 3'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) begin
        rinst[8]   = 1'b1;
        rinst[7]   = 1'b0;
        rinst[6:3] = 4'b0001;
      end
      run_txn(12'($urandom), rinst, 1'($urandom), ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
